// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the core's M-stage data port. Holds a
//   word-organised RAM with byte/halfword store merging and load extension,
//   plus an 8-byte MMIO window (tohost at offset 0, free-running cycle
//   counter at offset 4). The port has no handshake: reads are
//   combinational and stores commit on the rising clock edge.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   dmemAddr     byte address from the M stage
//   dmemWdata    store data, relevant bytes in the LSBs
//   dmemSize     funct3 of the access (B, H, W, BU, HU; reserved codes act as W)
//   dmemWen      store strobe
//   dmemRdata    extended load data (combinational)
//   toHost       last value stored to MMIO_BASE+0
//   done         sticky, set by any store to tohost
//   misalignErr  sticky misaligned-store flag
//   errAddr      address of the first misaligned store
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic [31:0] toHost,
  output logic        done,
  output logic        misalignErr,
  output logic [31:0] errAddr
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] cycleCnt;

  logic [IDX_W-1:0] idx;
  logic [1:0]       addrLo;
  logic             isMmio;
  logic             inRange;
  logic             misaligned;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic [31:0]      fetchWord;

  // B/BU never misalign; H/HU need an even address; W and reserved codes
  // need word alignment.
  function automatic logic isMisaligned(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] storeEnables(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000, 3'b100: return 4'b0001 << a;
      3'b001, 3'b101: return 4'b0011 << {a[1], 1'b0};
      default:        return 4'b1111;
    endcase
  endfunction

  // Replicate the narrow store data across lanes so the enables alone pick
  // which bytes land.
  function automatic logic [31:0] storeLanes(input logic [2:0] size, input logic [31:0] d);
    case (size)
      3'b000, 3'b100: return {4{d[7:0]}};
      3'b001, 3'b101: return {2{d[15:0]}};
      default:        return d;
    endcase
  endfunction

  function automatic logic [31:0] loadExtend(input logic [31:0] w, input logic [2:0] size,
                                             input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign idx        = dmemAddr[IDX_W+1:2];
  assign addrLo     = dmemAddr[1:0];
  assign isMmio     = dmemAddr[31:3] == MMIO_BASE[31:3];
  assign inRange    = {1'b0, dmemAddr} < RAM_BYTES;
  assign misaligned = isMisaligned(dmemSize, addrLo);
  assign byteEn     = storeEnables(dmemSize, addrLo);
  assign laneData   = storeLanes(dmemSize, dmemWdata);

  // MMIO decode wins over RAM so a window placed inside RAM still works.
  always_comb begin
    fetchWord = 32'd0;
    if (isMmio)
      fetchWord = dmemAddr[2] ? cycleCnt : toHost;
    else if (inRange)
      fetchWord = mem[idx];
  end

  // Misaligned reads return 0 silently: non-load instructions also present
  // addresses here, so flagging them would raise false errors.
  assign dmemRdata = misaligned ? 32'd0 : loadExtend(fetchWord, dmemSize, addrLo);

  // RAM contents are not reset; a store under reset is simply dropped.
  always_ff @(posedge clk) begin
    if (dmemWen && !rst && inRange && !isMmio && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[idx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt    <= 32'd0;
      toHost      <= 32'd0;
      done        <= 1'b0;
      misalignErr <= 1'b0;
      errAddr     <= 32'd0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (dmemWen) begin
        if (misaligned) begin
          misalignErr <= 1'b1;
          // Keep the first offending address only.
          if (!misalignErr) errAddr <= dmemAddr;
        end else if (isMmio && !dmemAddr[2]) begin
          for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) toHost[8*i +: 8] <= laneData[8*i +: 8];
          end
          done <= 1'b1;
        end
      end
    end
  end

endmodule
